imem_loader: RTL

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader_pkg.sv | 18 +
 rtl/word_assembler.sv | 40 ++++
 rtl/imem_loader.sv | 110 +++++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared constants and the loader FSM state encoding.
//   DEPTH          - instruction-memory depth in 32-bit words
//   AW             - word-address width (DEPTH == 2**AW)
//   BYTES_PER_WORD - bytes assembled per memory word
package imem_loader_pkg;
  localparam int DEPTH          = 32;
  localparam int AW             = 5;
  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    S_LEN  = 3'd0,
    S_BYTE = 3'd1,
    S_WR   = 3'd2,
    S_CHK  = 3'd3,
    S_DONE = 3'd4,
    S_ERR  = 3'd5
  } state_t;
endpackage

// File: rtl/word_assembler.sv
// word_assembler: big-endian byte-to-word shift register with byte counter.
//   clk, reset  - clock, async active-high reset
//   clr         - synchronous clear of the partial word and counter
//   shift_en    - accept din into the word this cycle
//   din         - incoming byte
//   word_next   - word as it stands once din is shifted in
//   word_full   - this cycle's byte completes a word
module word_assembler
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clr,
  input  logic        shift_en,
  input  logic [7:0]  din,
  output logic [31:0] word_next,
  output logic        word_full
);
  localparam int CW = $clog2(BYTES_PER_WORD);

  logic [CW-1:0] cnt;
  logic [31:0]   word;

  // First byte ends up in [31:24] after three further shifts.
  assign word_next = {word[23:0], din};
  assign word_full = shift_en && (cnt == CW'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt  <= '0;
      word <= '0;
    end else if (clr) begin
      cnt  <= '0;
      word <= '0;
    end else if (shift_en) begin
      word <= word_next;
      cnt  <= word_full ? '0 : cnt + 1'b1;
    end
  end
endmodule

// File: rtl/imem_loader.sv
// imem_loader: loads a length-prefixed, XOR-checksummed byte stream into an
// external instruction memory and releases the core from reset on success.
//   clk, reset          - clock, async active-high reset
//   in_data/in_valid    - load-stream byte and its valid
//   in_ready            - byte accepted when in_valid && in_ready
//   im_we/im_addr/im_wdata - one-cycle write strobe, word address, data
//   core_rst            - low only after a successful load
//   done / err          - sticky success / abort flags
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH = imem_loader_pkg::DEPTH,
  parameter int AW    = imem_loader_pkg::AW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [7:0]    in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          im_we,
  output logic [AW-1:0] im_addr,
  output logic [31:0]   im_wdata,
  output logic          core_rst,
  output logic          done,
  output logic          err
);
  state_t        state, nstate;
  logic [AW-1:0] idx;
  logic [AW-1:0] len_m1;   // L-1: index of the last word
  logic [7:0]    chk;
  logic          len_ok;
  logic          asm_clr, asm_shift, word_full;
  logic [31:0]   word_next;

  assign len_ok = (in_data != 8'd0) && ({24'd0, in_data} <= 32'(DEPTH));

  word_assembler u_asm (
    .clk       (clk),
    .reset     (reset),
    .clr       (asm_clr),
    .shift_en  (asm_shift),
    .din       (in_data),
    .word_next (word_next),
    .word_full (word_full)
  );

  always_comb begin
    nstate    = state;
    in_ready  = 1'b0;
    im_we     = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    core_rst  = 1'b1;
    asm_clr   = 1'b0;
    asm_shift = 1'b0;
    case (state)
      S_LEN: begin
        in_ready = 1'b1;
        asm_clr  = 1'b1;
        if (in_valid) nstate = len_ok ? S_BYTE : S_ERR;
      end
      S_BYTE: begin
        in_ready  = 1'b1;
        asm_shift = in_valid;
        if (word_full) nstate = S_WR;
      end
      S_WR: begin
        im_we  = 1'b1;
        nstate = (idx == len_m1) ? S_CHK : S_BYTE;
      end
      S_CHK: begin
        in_ready = 1'b1;
        if (in_valid) nstate = (in_data == chk) ? S_DONE : S_ERR;
      end
      S_DONE: begin
        done     = 1'b1;
        core_rst = 1'b0;
      end
      S_ERR:   err    = 1'b1;
      default: nstate = S_LEN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_LEN;
      idx      <= '0;
      len_m1   <= '0;
      chk      <= '0;
      im_addr  <= '0;
      im_wdata <= '0;
    end else begin
      state <= nstate;
      if (state == S_LEN && in_valid) begin
        len_m1 <= AW'(in_data - 8'd1);
        chk    <= in_data;
        idx    <= '0;
      end
      if (state == S_BYTE && in_valid) chk <= chk ^ in_data;
      // Address/data are captured with the 4th byte so they are valid during
      // the S_WR strobe and then simply hold until the next word.
      if (word_full) begin
        im_addr  <= idx;
        im_wdata <= word_next;
      end
      // Stop advancing on the last word so the index never wraps.
      if (state == S_WR && idx != len_m1) idx <= idx + 1'b1;
    end
  end
endmodule
